// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter, pipeline writeback first, multdiv results queued in a small FIFO.
// Define WB_BYPASS_EN to add registered bypass outputs bypValid/bypRd/bypData.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CW    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] oIn,
  input  logic [31:0] dIn,
  input  logic [4:0]  rdIn,
  input  logic        wRegIn,
  input  logic        lwIn,
  input  logic        mdReady,
  input  logic [31:0] mdResult,
  input  logic [4:0]  mdRd,
  output logic        rfWe,
  output logic [4:0]  rfRd,
  output logic [31:0] rfData,
  output logic        stallOut,
  output logic        mdPending,
  output logic        overflow
`ifdef WB_BYPASS_EN
  ,
  output logic        bypValid,
  output logic [4:0]  bypRd,
  output logic [31:0] bypData
`endif
);
  localparam int N = 2 ** CW;
  logic [31:0]   data_q [N];
  logic [4:0]    rd_q [N];
  logic [N-1:0]  vld_q, vld_d;
  logic [CW-1:0] wp_q, wp_d, rp_q, rp_d, cnt_q, cnt_d;
  logic          stall_q, stall_d, ovf_q, ovf_d;
  logic          pipe_wr, md_req, full, pop, enq, md_we;

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pipe_wr   = wRegIn & (rdIn != '0);
  assign md_req    = mdReady & (mdRd != '0);
  assign full      = cnt_q == CW'(DEPTH);
  assign pop       = ~pipe_wr & (cnt_q != '0);
  assign enq       = md_req & (~full | pop);
  assign md_we     = pop & vld_q[rp_q];
  assign rfWe      = pipe_wr | md_we;
  assign rfRd      = pipe_wr ? rdIn : md_we ? rd_q[rp_q] : '0;
  assign rfData    = pipe_wr ? (lwIn ? dIn : oIn) : md_we ? data_q[rp_q] : '0;
  assign stallOut  = stall_q;
  assign mdPending = cnt_q != '0;
  assign overflow  = ovf_q;

  // Squash runs before enqueue so a same-cycle multdiv result to rdIn survives.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (pipe_wr && rd_q[i] == rdIn) vld_d[i] = 1'b0;
    if (pop) vld_d[rp_q] = 1'b0;
    if (enq) vld_d[wp_q] = 1'b1;
    rp_d    = pop ? inc(rp_q) : rp_q;
    wp_d    = enq ? inc(wp_q) : wp_q;
    cnt_d   = cnt_q + CW'(enq) - CW'(pop);
    stall_d = cnt_d >= CW'(DEPTH - 1);
    ovf_d   = ovf_q | (md_req & full & ~pop);
  end

  always_ff @(posedge clock)
    if (enq) begin
      data_q[wp_q] <= mdResult;
      rd_q[wp_q]   <= mdRd;
    end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      vld_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end

`ifdef WB_BYPASS_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bypValid <= 1'b0;
      bypRd    <= '0;
      bypData  <= '0;
    end else begin
      bypValid <= rfWe;
      bypRd    <= rfRd;
      bypData  <= rfData;
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed plus randomized checks of wb_arbiter against a queue-based writeback model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] oIn, dIn, mdResult, rfData;
  logic [4:0]  rdIn, mdRd, rfRd;
  logic        wRegIn, lwIn, mdReady, rfWe, stallOut, mdPending, overflow;
  int total = 0;
  int passed = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        v;
  } ent_t;
  ent_t mq[$];
  logic m_stall = 1'b0;
  logic m_ovf = 1'b0;

  wb_arbiter #(.DEPTH(DEPTH), .CW(3)) dut (
    .clock(clock), .reset(reset), .oIn(oIn), .dIn(dIn), .rdIn(rdIn),
    .wRegIn(wRegIn), .lwIn(lwIn), .mdReady(mdReady), .mdResult(mdResult),
    .mdRd(mdRd), .rfWe(rfWe), .rfRd(rfRd), .rfData(rfData),
    .stallOut(stallOut), .mdPending(mdPending), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic set_in(input logic w, input logic lw, input logic [4:0] rd, input logic [31:0] o,
                        input logic [31:0] d, input logic mr, input logic [4:0] mrd, input logic [31:0] mres);
    wRegIn = w; lwIn = lw; rdIn = rd; oIn = o; dIn = d;
    mdReady = mr; mdRd = mrd; mdResult = mres;
  endtask

  task automatic nxt;
    @(posedge clock);
    #1;
  endtask

  // Model: evaluate outputs mid-cycle, then advance the queue to what the coming edge should produce.
  initial begin
    logic        pw, ew, pop, full;
    logic [4:0]  er;
    logic [31:0] ed;
    forever begin
      @(negedge clock);
      if (!reset) begin
        mq.delete();
        m_stall = 1'b0;
        m_ovf = 1'b0;
        chk("rst_we", rfWe, 0);
        chk("rst_pending", mdPending, 0);
        chk("rst_stall", stallOut, 0);
        chk("rst_overflow", overflow, 0);
      end else begin
        pw = wRegIn && rdIn != 0;
        ew = 0; er = 0; ed = 0;
        if (pw) begin ew = 1; er = rdIn; ed = lwIn ? dIn : oIn; end
        else if (mq.size() != 0 && mq[0].v) begin ew = 1; er = mq[0].rd; ed = mq[0].data; end
        chk("we", rfWe, ew);
        if (ew) begin
          chk("rd", rfRd, er);
          chk("data", rfData, ed);
        end
        chk("stall", stallOut, m_stall);
        chk("pending", mdPending, mq.size() != 0);
        chk("overflow", overflow, m_ovf);
        full = mq.size() == DEPTH;
        pop = !pw && mq.size() != 0;
        if (pw) for (int i = 0; i < mq.size(); i++) if (mq[i].rd == rdIn) mq[i].v = 0;
        if (pop) void'(mq.pop_front());
        if (mdReady && mdRd != 0) begin
          if (full && !pop) m_ovf = 1;
          else mq.push_back('{mdRd, mdResult, 1'b1});
        end
        m_stall = mq.size() >= DEPTH - 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    nxt();
    reset = 1'b1;
    nxt();
    // pipeline-only writes
    set_in(1, 1, 5, 32'h1234, 32'hDEADBEEF, 0, 0, 0);
    @(negedge clock);
    chk("pipe_lw_we", rfWe, 1);
    chk("pipe_lw_rd", rfRd, 5);
    chk("pipe_lw_data", rfData, 32'hDEADBEEF);
    nxt(); lwIn = 0;
    @(negedge clock);
    chk("pipe_alu_data", rfData, 32'h1234);
    nxt(); rdIn = 0;
    @(negedge clock);
    chk("pipe_r0_we", rfWe, 0);
    nxt();
    // idle drain, one-cycle latency
    set_in(0, 0, 0, 0, 0, 1, 7, 32'h64);
    @(negedge clock);
    chk("drain_lat0_we", rfWe, 0);
    nxt(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("drain_we", rfWe, 1);
    chk("drain_rd", rfRd, 7);
    chk("drain_data", rfData, 32'h64);
    chk("drain_pending", mdPending, 1);
    nxt();
    @(negedge clock);
    chk("drain_pending_clr", mdPending, 0);
    nxt();
    // contention
    set_in(1, 0, 3, 32'h33, 0, 1, 9, 32'hAA);
    nxt(); mdReady = 0;
    @(negedge clock);
    chk("cont_stall", stallOut, 1);
    chk("cont_pending", mdPending, 1);
    chk("cont_rd_pipe", rfRd, 3);
    nxt(); wRegIn = 0;
    @(negedge clock);
    chk("cont_we", rfWe, 1);
    chk("cont_rd", rfRd, 9);
    chk("cont_data", rfData, 32'hAA);
    nxt();
    @(negedge clock);
    chk("cont_stall_clr", stallOut, 0);
    nxt();
    // squash
    set_in(1, 0, 3, 32'h33, 0, 1, 4, 32'h11);
    nxt(); set_in(1, 0, 4, 32'h22, 0, 0, 0, 0);
    @(negedge clock);
    chk("sq_pipe_rd", rfRd, 4);
    chk("sq_pipe_data", rfData, 32'h22);
    nxt(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("sq_drain_we", rfWe, 0);
    chk("sq_drain_pending", mdPending, 1);
    nxt();
    @(negedge clock);
    chk("sq_pending_clr", mdPending, 0);
    nxt();
    // overflow
    set_in(1, 0, 3, 32'h1, 0, 1, 10, 32'h100);
    nxt(); mdRd = 11; mdResult = 32'h101;
    nxt(); mdRd = 12; mdResult = 32'h102;
    @(negedge clock);
    chk("ovf_before", overflow, 0);
    nxt(); mdReady = 0;
    @(negedge clock);
    chk("ovf_set", overflow, 1);
    chk("ovf_stall", stallOut, 1);
    nxt(); wRegIn = 0;
    @(negedge clock);
    chk("ovf_d1_rd", rfRd, 10);
    chk("ovf_d1_data", rfData, 32'h100);
    nxt();
    @(negedge clock);
    chk("ovf_d2_rd", rfRd, 11);
    chk("ovf_d2_data", rfData, 32'h101);
    nxt();
    @(negedge clock);
    chk("ovf_d3_we", rfWe, 0);
    chk("ovf_held", overflow, 1);
    nxt();
    // asynchronous reset with two entries queued
    set_in(1, 0, 3, 32'h1, 0, 1, 13, 32'h200);
    nxt(); mdRd = 14; mdResult = 32'h201;
    nxt(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("arst_pending", mdPending, 0);
    chk("arst_stall", stallOut, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_we", rfWe, 0);
    nxt(); reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("arst_no_write", rfWe, 0);
      nxt();
    end
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      wRegIn = (m_stall && $urandom_range(0, 9) < 8) ? 1'b0 : 1'($urandom_range(0, 1));
      lwIn = 1'($urandom_range(0, 1));
      rdIn = 5'($urandom_range(0, 7));
      oIn = $urandom;
      dIn = $urandom;
      mdReady = $urandom_range(0, 9) < 3;
      mdRd = 5'($urandom_range(0, 7));
      mdResult = $urandom;
      reset = (k % 600 == 599) ? 1'b0 : 1'b1;
      nxt();
    end
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) nxt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage consumer of the memory/writeback pipeline latch outputs.
- Selects ALU result vs load data and drives the register-file write port.
- Merges asynchronous multdiv completions through a small pending FIFO.
- Pipeline writeback always wins the port. Queued multdiv results drain in free cycles, with stall, squash and overflow handling.

Parameters:
- DEPTH, 2, multdiv pending FIFO entries (legal 2..8).
- CW, 3, FIFO count width; must satisfy 2^CW > DEPTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- oIn  in  32  ALU/address result from MW latch
- dIn  in  32  load data from MW latch
- rdIn  in  5  destination register from MW latch
- wRegIn  in  1  MW latch instruction writes a register
- lwIn  in  1  1 = write dIn, 0 = write oIn
- mdReady  in  1  single-cycle pulse: multdiv result valid
- mdResult  in  32  multdiv result
- mdRd  in  5  multdiv destination register
- rfWe  out  1  register-file write enable
- rfRd  out  5  register-file write address
- rfData  out  32  register-file write data
- stallOut  out  1  registered; pipeline inserts bubbles while high
- mdPending  out  1  FIFO non-empty
- overflow  out  1  sticky error flag

Behaviour:
- Reset (async, reset low): FIFO empty, count=0, all valid bits 0, stallOut=0, overflow=0. With the FIFO empty, rfWe=0 unless pipeline inputs request a write.
- pipeWr = wRegIn & (rdIn != 0).
- Pipeline write is combinational, same cycle: rfWe=1, rfRd=rdIn, rfData = lwIn ? dIn : oIn.
- Register 0 is never written from either source. mdReady with mdRd==0 is dropped: not enqueued, no error.
- Drain: when pipeWr=0 and the head entry is valid, it drives the port that cycle: rfWe=1, rfRd=head rd, rfData=head data. The entry is popped at the next edge.
- A head entry that has been squashed is popped with rfWe=0, using one cycle.
- Enqueue: mdReady with mdRd!=0 writes the tail at the edge. Earliest port write is the following cycle (latency 1 minimum).
- Simultaneous enqueue and pop in one cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Squash: when pipeWr=1, every valid FIFO entry with rd==rdIn has its valid bit cleared at the edge. The younger pipeline write wins.
- An mdReady in the same cycle with mdRd==rdIn is not squashed. The multdiv result is architecturally younger.
- stallOut next value is 1 when post-update count >= DEPTH-1, else 0.
- While stallOut=1 the pipeline presents wRegIn=0, guaranteeing a drain slot.
- Full: mdReady while count==DEPTH and no pop this cycle → result discarded, overflow set to 1 and held until reset. FIFO contents are unchanged.
- mdPending = (count != 0).
- Reset mid-drain: queued results are lost. Outputs return to reset values immediately (asynchronously).

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds registered outputs bypValid(1), bypRd(5), bypData(32). They capture rfWe/rfRd/rfData at every edge, so decode can forward the previous cycle's write (register file writes on the falling edge). Reset value is 0.
- bypValid is cleared at the next edge if that cycle's port write is suppressed.
- Not defined: the ports do not exist and no extra flops are built.

Test Plan:
- Pipeline only: wRegIn=1, lwIn=1, rdIn=5, dIn=0xDEADBEEF, oIn=0x1234 → same cycle rfWe=1, rfRd=5, rfData=0xDEADBEEF. Repeat with lwIn=0 → rfData=0x1234. rdIn=0 → rfWe=0.
- Idle drain: mdReady pulse, mdRd=7, mdResult=0x00000064, no pipeline write → rfWe=1, rfRd=7, rfData=0x64 exactly one cycle later. mdPending is 1 for one cycle, then 0.
- Contention: pipeline writes r3 every cycle while mdReady delivers r9=0xAA → FIFO holds it. stallOut=1 after count reaches 1 (DEPTH=2). Bench drops wRegIn → r9 written on the first free cycle.
- Squash: queue r4=0x11 under contention, then pipeline writes r4=0x22 → FIFO entry invalidated; the later drain cycle shows rfWe=0; final r4=0x22.
- Overflow: DEPTH=2, hold wRegIn=1 (ignore stall), three mdReady pulses → overflow=1 after the third. Only the first two results are later written. overflow stays 1 until reset is asserted low.
- Async reset mid-queue: two entries queued, assert reset low between edges → mdPending, stallOut, overflow=0 immediately. No queued write appears after release.
